// File: rtl/apple2_sd_pkg.sv
// Shared types for the Apple II SD channel scheduler: state encoding, channel/direction codes, and the FDD job record.
package apple2_sd_pkg;
  localparam int SECTORS_PER_TRACK = 13;
  localparam int SEC_W = 4;
  localparam int REM_W = 5;

  localparam logic CHAN_FDD = 1'b0;
  localparam logic CHAN_HDD = 1'b1;
  localparam logic DIR_RD   = 1'b0;
  localparam logic DIR_WR   = 1'b1;

  typedef enum logic [1:0] {ARB, ISSUE, WAIT_RISE, WAIT_FALL} state_t;

  typedef struct packed {
    logic             dir;
    logic             chan;
    logic [31:0]      base_lba;
    logic [SEC_W-1:0] sec;
    logic [REM_W-1:0] remaining;
  } job_t;
endpackage

// File: rtl/sd_sector_handshake.sv
// One-sector SD handshake: raises rd or wr on start, drops it on the ack rise, strobes done on the ack fall.
module sd_sector_handshake (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic start,
  input  logic dir,
  input  logic ack,
  output logic rd,
  output logic wr,
  output logic rise,
  output logic done
);
  logic ack_q, acked;

  // Edges only count while this sector is outstanding; stray acks are ignored.
  assign rise = (rd | wr) & ack & ~ack_q;
  assign done = acked & ~ack & ack_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ack_q <= 1'b0;
      acked <= 1'b0;
      rd    <= 1'b0;
      wr    <= 1'b0;
    end else begin
      ack_q <= ack;
      if (start) begin
        rd    <= ~dir;
        wr    <= dir;
        acked <= 1'b0;
      end else if (rise) begin
        rd    <= 1'b0;
        wr    <= 1'b0;
        acked <= 1'b1;
      end else if (done) begin
        acked <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/apple2_sd_scheduler.sv
// Arbitrates the single SD sector channel between the Disk II track buffer and the HDD sector buffer.
module apple2_sd_scheduler #(
  parameter int SECTORS_PER_TRACK = apple2_sd_pkg::SECTORS_PER_TRACK,
  parameter int TRACK_W           = 6
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [TRACK_W-1:0] track,
  input  logic               fdd_mounted,
  input  logic               fdd_present,
  input  logic               fdd_dirty_set,
  input  logic               hdd_read,
  input  logic               hdd_write,
  input  logic [31:0]        hdd_lba,
  input  logic               sd_ack,
  output logic [31:0]        sd_lba,
  output logic               sd_rd,
  output logic               sd_wr,
  output logic               sd_chan,
  output logic [3:0]         fdd_sec,
  output logic               cpu_wait_fdd,
  output logic               cpu_wait_hdd
);
  import apple2_sd_pkg::*;

  state_t             state, next;
  job_t               job;
  logic [TRACK_W-1:0] cur_track;
  logic               fdd_loaded, dirty, mount_pend;
  logic               rd_pend, wr_pend, cur_dir;
  logic [31:0]        hdd_lba_q;
  logic               hdd_pend, need, fdd_go, hdd_go, job_start;
  logic               issue, sector_done, ack_rise, ack_done;

  function automatic logic [31:0] track_lba(input logic [TRACK_W-1:0] t);
    return 32'(SECTORS_PER_TRACK) * 32'(t);
  endfunction

  function automatic job_t make_job(input logic dir, input logic [31:0] base);
    job_t j;
    j.dir       = dir;
    j.chan      = CHAN_FDD;
    j.base_lba  = base;
    j.sec       = '0;
    j.remaining = REM_W'(SECTORS_PER_TRACK);
    return j;
  endfunction

  assign hdd_pend     = rd_pend | wr_pend;
  assign need         = (track != cur_track) || mount_pend;
  assign fdd_go       = (state == ARB) && (job.remaining != '0) && !hdd_pend;
  assign hdd_go       = (state == ARB) && !fdd_go && hdd_pend;
  assign job_start    = (state == ARB) && (job.remaining == '0) && !hdd_pend && need;
  assign cpu_wait_fdd = (job.remaining != '0);
  assign cpu_wait_hdd = hdd_pend;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= ARB;
    else          state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      ARB:       if (fdd_go || hdd_go) next = ISSUE;
      ISSUE:     next = WAIT_RISE;
      WAIT_RISE: if (ack_rise) next = WAIT_FALL;
      WAIT_FALL: if (ack_done) next = ARB;
      default:   next = ARB;
    endcase
  end

  always_comb begin
    issue       = (state == ISSUE);
    sector_done = (state == WAIT_FALL) && ack_done;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      job        <= '0;
      cur_track  <= '0;
      fdd_loaded <= 1'b0;
      dirty      <= 1'b0;
      mount_pend <= 1'b0;
      rd_pend    <= 1'b0;
      wr_pend    <= 1'b0;
      cur_dir    <= 1'b0;
      hdd_lba_q  <= '0;
      sd_lba     <= '0;
      sd_chan    <= 1'b0;
      fdd_sec    <= '0;
    end else begin
      if (fdd_go) begin
        sd_lba  <= job.base_lba + 32'(job.sec);
        sd_chan <= job.chan;
        fdd_sec <= job.sec;
        cur_dir <= job.dir;
      end
      if (hdd_go) begin
        sd_lba  <= hdd_lba_q;
        sd_chan <= CHAN_HDD;
        cur_dir <= wr_pend ? DIR_WR : DIR_RD;
      end

      if (job_start) begin
        if (!fdd_present) begin
          cur_track  <= track;
          fdd_loaded <= 1'b0;
          mount_pend <= 1'b0;
        end else if (dirty && fdd_loaded && !mount_pend) begin
          job   <= make_job(DIR_WR, track_lba(cur_track));
          dirty <= 1'b0;
        end else begin
          job        <= make_job(DIR_RD, track_lba(track));
          cur_track  <= track;
          mount_pend <= 1'b0;
        end
      end

      if (sector_done) begin
        if (sd_chan == CHAN_HDD) begin
          if (cur_dir == DIR_WR) wr_pend <= 1'b0;
          else                   rd_pend <= 1'b0;
        end else begin
          job.sec       <= job.sec + 1'b1;
          job.remaining <= job.remaining - 1'b1;
          if (job.remaining == REM_W'(1)) begin
            // A finished write-back chains straight into the load so the CPU stall never gaps.
            if (job.dir == DIR_WR) begin
              job        <= make_job(DIR_RD, track_lba(track));
              cur_track  <= track;
              mount_pend <= 1'b0;
            end else begin
              fdd_loaded <= 1'b1;
            end
          end
        end
      end

      // Request latching comes last so a new pulse wins over a same-cycle clear.
      if (hdd_read)  rd_pend <= 1'b1;
      if (hdd_write) wr_pend <= 1'b1;
      if (hdd_read || hdd_write) hdd_lba_q <= hdd_lba;
      if (fdd_mounted) begin
        mount_pend <= 1'b1;
        dirty      <= 1'b0;
      end
      if (fdd_dirty_set) dirty <= 1'b1;
    end
  end

  sd_sector_handshake u_hs (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .start   (issue),
    .dir     (cur_dir),
    .ack     (sd_ack),
    .rd      (sd_rd),
    .wr      (sd_wr),
    .rise    (ack_rise),
    .done    (ack_done)
  );
endmodule

// File: tb/tb_apple2_sd_scheduler.sv
// Bench for apple2_sd_scheduler: random-latency SD host, transfer log, and a track/dirty/mount reference model.
module tb_apple2_sd_scheduler;
  localparam int SPT = 13;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  track = '0;
  logic        fdd_mounted = 1'b0, fdd_present = 1'b1, fdd_dirty_set = 1'b0;
  logic        hdd_read = 1'b0, hdd_write = 1'b0, sd_ack = 1'b0;
  logic [31:0] hdd_lba = '0;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, sd_chan, cpu_wait_fdd, cpu_wait_hdd;
  logic [3:0]  fdd_sec;

  int total = 0, bad = 0;

  typedef struct {
    logic [31:0] lba;
    logic        wr;
    logic        chan;
    logic [3:0]  sec;
  } xfer_t;
  xfer_t log_q[$], exp_q[$];

  int m_cur = 0;
  bit m_loaded = 0, m_dirty = 0, m_mount = 0, m_present = 1;

  apple2_sd_scheduler dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .track(track), .fdd_mounted(fdd_mounted),
    .fdd_present(fdd_present), .fdd_dirty_set(fdd_dirty_set), .hdd_read(hdd_read),
    .hdd_write(hdd_write), .hdd_lba(hdd_lba), .sd_ack(sd_ack), .sd_lba(sd_lba),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_chan(sd_chan), .fdd_sec(fdd_sec),
    .cpu_wait_fdd(cpu_wait_fdd), .cpu_wait_hdd(cpu_wait_hdd)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // SD host: answers each request after a random delay, holds ack for a random span.
  initial begin
    xfer_t r;
    int    d, n;
    forever begin
      @(posedge clk_sys); #1;
      if (reset_n && (sd_rd || sd_wr)) begin
        d = $urandom_range(0, 3);
        for (int k = 0; k < d; k++) begin @(posedge clk_sys); #1; end
        if (reset_n && (sd_rd || sd_wr)) begin
          r.lba = sd_lba; r.wr = sd_wr; r.chan = sd_chan; r.sec = fdd_sec;
          log_q.push_back(r);
          if (r.chan) check("wait_hdd_in_xfer", cpu_wait_hdd, 1);
          else        check("wait_fdd_in_xfer", cpu_wait_fdd, 1);
          sd_ack = 1'b1;
          n = $urandom_range(2, 5);
          for (int k = 0; k < n && reset_n; k++) begin @(posedge clk_sys); #1; end
          if (reset_n) begin
            check("lba_stable", sd_lba, r.lba);
            check("chan_stable", sd_chan, r.chan);
          end
          sd_ack = 1'b0;
        end
      end
    end
  end

  task automatic push_exp(input int lba, input bit wr, input bit chan, input int sec);
    xfer_t x;
    x.lba = 32'(lba); x.wr = wr; x.chan = chan; x.sec = sec[3:0];
    exp_q.push_back(x);
  endtask

  task automatic m_job(input int t, input bit wr);
    for (int i = 0; i < SPT; i++) push_exp(SPT * t + i, wr, 1'b0, i);
  endtask

  // Reference: what a quiescent drive does once the head sits on track t.
  task automatic m_track(input int t);
    if (t != m_cur || m_mount) begin
      if (!m_present) begin
        m_loaded = 0;
      end else begin
        if (m_dirty && m_loaded && !m_mount) begin
          m_job(m_cur, 1'b1);
          m_dirty = 0;
        end
        m_job(t, 1'b0);
        m_loaded = 1;
      end
      m_cur = t;
      m_mount = 0;
    end
  endtask

  task automatic wait_idle();
    int q = 0, n = 0;
    while (q < 6 && n < 4000) begin
      @(negedge clk_sys); n++;
      if (!(cpu_wait_fdd || cpu_wait_hdd || sd_rd || sd_wr || sd_ack)) q++;
      else q = 0;
    end
    check("idle_timeout", n < 4000, 1);
  endtask

  task automatic wait_log(input int cnt);
    int c = 0;
    while (log_q.size() < cnt && c < 3000) begin @(negedge clk_sys); c++; end
    check("log_timeout", c < 3000, 1);
  endtask

  task automatic compare_log(input string tag);
    check({tag, "_count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
      check({tag, "_lba"}, log_q[i].lba, exp_q[i].lba);
      check({tag, "_dir"}, log_q[i].wr, exp_q[i].wr);
      check({tag, "_chan"}, log_q[i].chan, exp_q[i].chan);
      if (!exp_q[i].chan) check({tag, "_sec"}, log_q[i].sec, exp_q[i].sec);
    end
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_dirty();
    @(negedge clk_sys); fdd_dirty_set = 1'b1;
    @(negedge clk_sys); fdd_dirty_set = 1'b0;
    m_dirty = 1;
  endtask

  task automatic pulse_hdd(input bit rd, input bit wr, input logic [31:0] lba);
    @(negedge clk_sys); hdd_read = rd; hdd_write = wr; hdd_lba = lba;
    @(negedge clk_sys); hdd_read = 1'b0; hdd_write = 1'b0;
  endtask

  initial begin
    xfer_t x;
    int    t, c;
    bit    seen;

    #1;
    check("rst_lba", sd_lba, 0);
    check("rst_rd", sd_rd, 0);
    check("rst_wr", sd_wr, 0);
    check("rst_chan", sd_chan, 0);
    check("rst_sec", fdd_sec, 0);
    check("rst_wait_fdd", cpu_wait_fdd, 0);
    check("rst_wait_hdd", cpu_wait_hdd, 0);
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;

    @(negedge clk_sys); track = 6'd3; m_track(3);
    wait_idle(); compare_log("load3");
    check("wait_fdd_after_load", cpu_wait_fdd, 0);

    pulse_dirty();
    @(negedge clk_sys); track = 6'd4; m_track(4);
    wait_idle(); compare_log("wb3_load4");

    for (int it = 0; it < 6; it++) begin
      if ($urandom_range(0, 1) == 1) pulse_dirty();
      t = (m_cur + 1 + $urandom_range(0, 61)) % 64;
      @(negedge clk_sys); track = 6'(t); m_track(t);
      wait_idle(); compare_log("rand_track");
    end

    // HDD read arrives while the 6th sector of the job is in flight.
    t = (m_cur == 40) ? 41 : 40;
    @(negedge clk_sys); track = 6'(t); m_track(t);
    x.lba = 32'h100; x.wr = 1'b0; x.chan = 1'b1; x.sec = '0;
    exp_q.insert(6, x);
    wait_log(6);
    pulse_hdd(1'b1, 1'b0, 32'h100);
    wait_idle(); compare_log("interleave");

    pulse_hdd(1'b1, 1'b1, 32'd7);
    push_exp(7, 1'b1, 1'b1, 0);
    push_exp(7, 1'b0, 1'b1, 0);
    wait_idle(); compare_log("hdd_wr_rd");
    check("wait_hdd_after", cpu_wait_hdd, 0);

    for (int it = 0; it < 4; it++) begin
      x.lba = $urandom; x.wr = 1'($urandom_range(0, 1));
      pulse_hdd(~x.wr, x.wr, x.lba);
      push_exp(int'(x.lba), x.wr, 1'b1, 0);
      wait_idle(); compare_log("rand_hdd");
    end

    fdd_present = 1'b0; m_present = 0;
    @(negedge clk_sys); track = 6'd2; m_track(2);
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk_sys);
      if (cpu_wait_fdd || sd_rd || sd_wr) seen = 1;
    end
    check("absent_no_activity", seen, 0);
    compare_log("absent");

    fdd_present = 1'b1; m_present = 1;
    @(negedge clk_sys); fdd_mounted = 1'b1;
    @(negedge clk_sys); fdd_mounted = 1'b0;
    m_mount = 1; m_dirty = 0; m_track(2);
    wait_idle(); compare_log("mount_reload");

    @(negedge clk_sys); track = 6'd9;
    wait_log(3);
    c = 0;
    while (!sd_rd && c < 500) begin @(negedge clk_sys); c++; end
    check("rd_seen_timeout", c < 500, 1);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_rd", sd_rd, 0);
    check("midrst_wait_fdd", cpu_wait_fdd, 0);
    check("midrst_wait_hdd", cpu_wait_hdd, 0);
    check("midrst_lba", sd_lba, 0);
    repeat (5) @(negedge clk_sys);
    log_q.delete(); exp_q.delete();
    m_cur = 0; m_loaded = 0; m_dirty = 0; m_mount = 0;
    reset_n = 1'b1; m_track(9);
    wait_idle(); compare_log("post_reset_load");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/apple2_sd_scheduler.md
Name: apple2_sd_scheduler

Overview:
- Shares the single SD sector channel (one lba/rd/wr/ack set) between the Disk II track buffer and the ProDOS HDD buffer.
- Sequences multi-sector FDD track loads and dirty-track write-backs.
- Interleaves single-sector HDD reads and writes at sector boundaries.
- Drives the per-requester CPU wait lines and the buffer select and index that steer sd_buff_* traffic.

Parameters:
- SECTORS_PER_TRACK, 13, 512-byte SD sectors per Disk II track
- TRACK_W, 6, track number width

Ports:
- clk_sys  in  1  system clock (14M domain)
- reset_n  in  1  asynchronous, active-low reset
- track  in  TRACK_W  current head track from the drive
- fdd_mounted  in  1  one-cycle pulse: floppy image (re)mounted
- fdd_present  in  1  floppy image size nonzero
- fdd_dirty_set  in  1  pulse: track buffer byte written by the drive
- hdd_read  in  1  pulse: HDD sector read request
- hdd_write  in  1  pulse: HDD sector write request
- hdd_lba  in  32  HDD sector address, sampled with the request pulse
- sd_ack  in  1  SD host acknowledge; high while a sector transfers
- sd_lba  out  32  sector address of the active transfer
- sd_rd  out  1  read request
- sd_wr  out  1  write request
- sd_chan  out  1  0 = FDD buffer, 1 = HDD buffer (buffer steering)
- fdd_sec  out  4  sector index within the FDD track buffer
- cpu_wait_fdd  out  1  stall CPU for floppy
- cpu_wait_hdd  out  1  stall CPU for HDD

Behaviour:
- Reset values:
  - All outputs 0.
  - Internal: cur_track=0, fdd_loaded=0, dirty=0, mount_pend=0, hdd pending flags clear, state ARB.
  - Reset is asynchronous; asserting it mid-transfer drops sd_rd/sd_wr immediately. The SD host is expected to abort.
- Latching, in every state:
  - hdd_read/hdd_write set rd_pend/wr_pend and capture hdd_lba.
  - If both pulse in the same cycle, wr is serviced first, then rd, both at the same lba.
  - fdd_mounted sets mount_pend and clears dirty.
  - fdd_dirty_set sets dirty.
- FDD need: (track != cur_track) || mount_pend.
- State machine:
  - ARB:
    - If a sector of an FDD job remains and no HDD request is pending, issue it.
    - Else if an HDD request is pending, issue it.
    - Else if FDD need: start a job.
      - If !fdd_present: cur_track<=track, fdd_loaded<=0, clear mount_pend; no SD traffic.
      - Else if dirty && fdd_loaded && !mount_pend: write-back job on cur_track, then a load job on track.
      - Else: load job. Latch cur_track<=track, clear mount_pend.
  - ISSUE: for one cycle, drive sd_lba/sd_chan/fdd_sec. From the next cycle rd or wr=1 → WAIT_RISE.
  - WAIT_RISE: on an ack rising edge (registered prior ack), drop rd/wr next cycle → WAIT_FALL.
  - WAIT_FALL: on an ack falling edge the sector is done. Advance the sector count or clear the HDD pending flag → ARB.
  - Next issue is no earlier than 1 cycle after the ack fall.
- HDD priority: HDD preempts an FDD job only at sector boundaries. An in-flight sector is never aborted.
- FDD lba arithmetic: SECTORS_PER_TRACK*trk + fdd_sec, computed at 32 bits and zero-extended. fdd_sec runs 0..SECTORS_PER_TRACK-1.
- Dirty handling: dirty is cleared when the write-back job starts. fdd_dirty_set during a write-back re-sets it.
- Timing stability: sd_lba, sd_chan and fdd_sec hold stable from ISSUE until the ack fall.
- An ack edge with no request outstanding is ignored.
- cpu_wait_fdd: 1 from the FDD job start cycle until the final sector's ack fall, including cycles when HDD sectors are interleaved.
- cpu_wait_hdd: 1 from the cycle after the request pulse until that sector's ack fall.
- Track changes during a job: the job completes on the latched track. ARB then re-evaluates need and loads again.
- fdd_mounted during a job: the job completes, then a forced reload runs with no write-back.
- fdd_loaded is set at load-job completion.

Decomposition:
- Package apple2_sd_pkg holds:
  - SECTORS_PER_TRACK
  - the CHAN_FDD/CHAN_HDD encodings
  - the state enum (ARB, ISSUE, WAIT_RISE, WAIT_FALL)
  - a job struct {dir, chan, base_lba, sec, remaining}
- One sub-module, sd_sector_handshake: ack edge detect plus rd/wr drive for one sector, with start/done strobes.

Test Plan:
- track 0→3, fdd_present=1, not dirty → 13 reads, lba 39..51, fdd_sec 0..12, sd_chan=0; cpu_wait_fdd high until the 13th ack fall.
- Loaded track 3, fdd_dirty_set, track→4 → 13 writes lba 39..51, then 13 reads lba 52..64; dirty=0 afterwards.
- hdd_read lba=0x100 during FDD sector 5 → sector 5 completes, then HDD read lba 0x100 with sd_chan=1, then FDD resumes at sector 6 (lba base+6).
- hdd_write and hdd_read same cycle, lba=7 → write to lba 7 then read lba 7; cpu_wait_hdd drops after the second ack fall.
- fdd_present=0, track 0→2 → no sd_rd; cur_track=2; cpu_wait_fdd stays 0.
- reset_n low while sd_rd=1 mid-load → sd_rd=0 and waits=0 in the same cycle; after release, track≠0 triggers a fresh 13-sector load.
